inverse_key_schedule: RTL
=========================

# inverse_key_schedule

Iterative AES-128 key scheduler for the decryption datapath. Accepts one cipher key, expands all round keys into an internal buffer at one key per cycle, then streams them in reverse order (round `NUM_ROUNDS` down to round 0) over a valid/ready handshake. It sits in front of the `BufferedRoundInverse` stages and supplies the key each inverse round consumes, mirroring the forward schedule used by the encryption rounds.

## Interface
- `NUM_ROUNDS`, default `` `NUM_ROUNDS `` (10): number of AES rounds; the buffer holds `NUM_ROUNDS+1` round keys.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `keyValid`  in  1  cipher key on `key` is valid.
- `keyReady`  out  1  block can accept a key (IDLE only).
- `key`  in  128  cipher key, FIPS-197 byte order (bits [127:120] = byte 0; w0 = [127:96]).
- `rkValid`  out  1  `roundKey` / `roundIndex` / `last` are valid.
- `rkReady`  in  1  consumer accepts the current round key.
- `roundKey`  out  128 (`roundKey_t`)  round key `roundIndex`.
- `roundIndex`  out  4  index of the presented key, `NUM_ROUNDS` down to 0.
- `last`  out  1  high with `rkValid` when `roundIndex` == 0.

## Operation
- FSM states: IDLE, EXPAND, STREAM.
- IDLE: `keyReady`=1, `rkValid`=0. On `keyValid && keyReady` → write `key` to buffer[0], clear the expansion counter, go to EXPAND.
- EXPAND: each cycle computes rk[i] = step(rk[i-1], Rcon[i]) for i = 1..`NUM_ROUNDS` and writes buffer[i]. The step is RotWord, SubWord, XOR Rcon on w3, followed by the chained XOR of w0..w3. After buffer[`NUM_ROUNDS`] is written → STREAM with read pointer = `NUM_ROUNDS`.
- STREAM: `rkValid`=1; `roundKey` = buffer[ptr], `roundIndex` = ptr. On `rkValid && rkReady`, ptr decrements. The handshake with ptr == 0 (`last`=1) returns the FSM to IDLE.
- `keyValid` is ignored outside IDLE. No abort input; only `reset` cancels a sequence.
- `roundKey` is a registered read of the buffer, so the outputs contain no combinational path from `rkReady`.

## Timing
- Reset values: FSM=IDLE, `keyReady`=1, `rkValid`=0, `last`=0, `roundIndex`=0, `roundKey`=0. Buffer contents are don't-care.
- Key acceptance at edge E0; expansion writes occur on edges E1..E`NUM_ROUNDS`. `rkValid` first rises in the cycle after E`NUM_ROUNDS`, i.e. `NUM_ROUNDS` cycles after acceptance (10 for AES-128).
- With `rkReady` held at 1: one key per cycle, 11 consecutive transfers. `keyReady` is high in the cycle after the `last` handshake.
- Stall: while `rkValid && !rkReady`, `roundKey`, `roundIndex` and `last` are held stable.
- Minimum key-to-key spacing: `NUM_ROUNDS` + `NUM_ROUNDS`+1 + 1 = 22 cycles.
- Reset asserted mid-EXPAND or mid-STREAM: on the next edge all outputs take reset values and the FSM is in IDLE; any partially streamed sequence is dropped.
- Reset and `keyValid` in the same cycle: reset wins and the key is not captured.

## Structure
- Shared package (`AESDefinitions`): `roundKey_t`, `key_t`, `NUM_ROUNDS`, the Rcon table, and the S-box / SubWord function reused from the forward rounds.
- Sub-module: `key_expand_step`, a combinational rk[i-1] + Rcon → rk[i] step. It is instantiated once and is reusable by the forward scheduler.
- Buffer: an 11×128 register array (no RAM macro), written by the expansion counter and read by the stream pointer.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c with `rkReady`=1 → after 10 cycles `roundIndex`=10, `roundKey`=d014f9a8c9ee2589e13f0cc8b6630ca6. Index 1 carries a0fafe1788542cb123a339392a6c7605; index 0 carries the key itself with `last`=1.
- Key 000102030405060708090a0b0c0d0e0f → first output 13111d7fe3944a17f307a78b4d2b30c5, index 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, final = the key. Outputs feed `BufferedRoundInverse` and must match `BufferedRoundInverse` expected outputs (e.g. the last inverse round on 6353e08c0960e104cd70b751bacad0e7 → 00112233445566778899aabbccddeeff).
- Random `rkReady` stalls (including holding it low for 5 cycles at index 10 and at index 0) → outputs stable during each stall, no index skipped or repeated, `last` only at index 0.
- `keyValid` pulsed with a different key during EXPAND and STREAM → ignored; the stream still matches the first key, and `keyReady`=0 throughout.
- Reset asserted at EXPAND cycle 5 and again at STREAM index 4 → the next cycle shows `rkValid`=0 and `keyReady`=1; a fresh key afterwards produces the full correct 11-key sequence.
- Back-to-back keys (the two above) with `keyValid` held → the second key is accepted exactly one cycle after the first `last` handshake, and its first output appears 10 cycles later.

Source files
------------

// File: rtl/inverse_key_schedule_pkg.sv
// Shared AES definitions: key types, round count, Rcon table and the S-box
// (computed as GF(2^8) inverse plus affine map) reused by the forward rounds.
package AESDefinitions;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] roundKey_t;
    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        STREAM = 2'd2
    } ks_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; zero maps to zero as AES requires.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t = x;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(gf_mul(t, t), x);
        end
        inv = gf_mul(t, t);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inverse_key_schedule_key_expand_step.sv
// One AES-128 key expansion step: rk[i-1] and Rcon[i] produce rk[i].
// Purely combinational so the forward scheduler can share it.
module key_expand_step
    import AESDefinitions::*;
(
    input  roundKey_t  prev_key_i,
    input  logic [7:0] rcon_i,
    output roundKey_t  next_key_o
);
    word_t w0, w1, w2, w3;
    word_t temp;
    word_t n0, n1, n2, n3;

    always_comb begin
        w0   = prev_key_i[127:96];
        w1   = prev_key_i[95:64];
        w2   = prev_key_i[63:32];
        w3   = prev_key_i[31:0];
        temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/inverse_key_schedule.sv
// Iterative AES-128 key scheduler for decryption: expands one key per cycle,
// then streams round keys NUM_ROUNDS..0 over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for a cipher key, keyReady high
// EXPAND | writing rk[1..NUM_ROUNDS] into the buffer, one per cycle
// STREAM | presenting buffer[ptr], ptr counts down to 0
module inverse_key_schedule
    import AESDefinitions::*;
#(
    parameter int NUM_ROUNDS = AESDefinitions::NUM_ROUNDS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       keyValid,
    output logic       keyReady,
    input  key_t       key,
    output logic       rkValid,
    input  logic       rkReady,
    output roundKey_t  roundKey,
    output logic [3:0] roundIndex,
    output logic       last
);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_e  state_q, state_d;
    logic [3:0] cnt_q;
    logic [3:0] ptr_q;
    roundKey_t  prev_q;
    roundKey_t  roundKey_q;
    roundKey_t  step_key;
    roundKey_t  rk_buf_q [NUM_ROUNDS+1];

    key_expand_step u_step (
        .prev_key_i (prev_q),
        .rcon_i     (rcon(cnt_q)),
        .next_key_o (step_key)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (keyValid) state_d = EXPAND;
            EXPAND:  if (cnt_q == LAST_IDX) state_d = STREAM;
            STREAM:  if (rkReady && ptr_q == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        keyReady = (state_q == IDLE);
        rkValid  = (state_q == STREAM);
        last     = (state_q == STREAM) && (ptr_q == 4'd0);
    end

    // The final expansion result bypasses the buffer so the first key is
    // presented the cycle after it is computed.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= 4'd0;
            ptr_q      <= 4'd0;
            prev_q     <= '0;
            roundKey_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (keyValid) begin
                        prev_q <= key;
                        cnt_q  <= 4'd1;
                    end
                end
                EXPAND: begin
                    prev_q <= step_key;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        roundKey_q <= step_key;
                        ptr_q      <= LAST_IDX;
                    end
                end
                STREAM: begin
                    if (rkReady && ptr_q != 4'd0) begin
                        roundKey_q <= rk_buf_q[ptr_q - 4'd1];
                        ptr_q      <= ptr_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && keyValid) rk_buf_q[0] <= key;
        else if (state_q == EXPAND)      rk_buf_q[cnt_q] <= step_key;
    end

    assign roundKey   = roundKey_q;
    assign roundIndex = ptr_q;

endmodule
